// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_adder_arbiter
// Description : Round-robin scheduler that shares one WIDTH-bit adder between
//               N_REQ requesters. Each cycle it grants at most one valid
//               requester, adds its operand pair modulo 2^WIDTH and parks the
//               sum plus the winner's ID in a one-entry output register until
//               the consumer takes it.
// Ports       : clk        - clock, rising-edge
//               rst_n      - asynchronous active-low reset
//               req_valid  - per-requester request valid      [N_REQ]
//               req_ready  - per-requester grant (one-hot/0)  [N_REQ]
//               req_a      - packed operand A, lane i at [i*WIDTH +: WIDTH]
//               req_b      - packed operand B, same packing
//               rsp_valid  - output register holds a result
//               rsp_ready  - consumer accepts the result
//               rsp_id     - index of the requester that produced the result
//               rsp_sum    - (a + b) mod 2^WIDTH
//               rsp_carry  - carry-out of the sum (SHARED_ADDER_CARRY_EN only)
// Config      : define SHARED_ADDER_CARRY_EN to add the registered rsp_carry
//               output; otherwise the carry is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum
`ifdef SHARED_ADDER_CARRY_EN
  ,
  output logic                   rsp_carry
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q;
  logic [WIDTH-1:0] sum_q;

  logic            accept;
  logic            found;
  logic            xfer;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_ext;
  logic [ID_W-1:0] scan_idx;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   sum_ext;

  // The register can take a new result when empty, or when the current one
  // leaves in this same cycle.
  assign accept = (state_q == ST_EMPTY) || rsp_ready;
  assign xfer   = accept && found;

  // Round-robin search starting at ptr_q; the index is computed one bit wider
  // so the wrap past N_REQ-1 also works for non-power-of-two N_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_ext  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_ext = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_ext >= (ID_W+1)'(N_REQ)) begin
        scan_ext = scan_ext - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_ext[ID_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Grant vector depends only on req_valid, ptr, state and rsp_ready.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && found && (grant_idx == ID_W'(i));
    end
  end

  // Operand mux for the winning lane feeding the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_ext = {1'b0, a_sel} + {1'b0, b_sel};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      ptr_d   = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // Payload only changes on a transfer, so it holds under backpressure
      // and keeps its last value after draining.
      if (xfer) begin
        id_q  <= grant_idx;
        sum_q <= sum_ext[WIDTH-1:0];
      end
    end
  end

`ifdef SHARED_ADDER_CARRY_EN
  logic carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (xfer) begin
      carry_q <= sum_ext[WIDTH];
    end
  end

  assign rsp_carry = carry_q;
`endif

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;

endmodule
`default_nettype wire

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Round-robin scheduler sharing one WIDTH-bit adder datapath between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the modular sum, and holds the result with the winner's ID in a one-entry output register until the consumer accepts it. It sits between the requesting units and the `add4`-style adder, so they never need private adders.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `WIDTH`, 4: operand and sum width in bits.
- `ID_W`, `$clog2(N_REQ)`: width of the requester ID. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester grant; one-hot or zero; combinational.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that produced the result.
- `rsp_sum`  out  WIDTH  sum (a + b) mod 2^WIDTH.

## Operation
- Output-register state machine:
  - EMPTY (reset state): `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Accept condition: `accept = (state==EMPTY) || rsp_ready`.
- Grant rule:
  - When `accept` is high, grant the first requester with `req_valid` set, searching from `ptr` upward and wrapping past N_REQ-1 to 0.
  - `req_ready[g]`=1 only for the winner g.
  - When `accept` is low, all `req_ready` bits are 0.
- A transfer occurs when `req_valid[g] && req_ready[g]`. On the next edge:
  - `rsp_sum` <= (a_g + b_g) truncated to WIDTH bits; the carry-out is discarded (wrap-around).
  - `rsp_id` <= g; state goes to FULL.
  - `ptr` <= (g+1) mod N_REQ.
- Response handshake with no new grant in the same cycle: FULL -> EMPTY; `rsp_sum` and `rsp_id` hold their values.
- Simultaneous response handshake and grant: state stays FULL and the register reloads with the new result. Full throughput is one result per cycle.
- No request while EMPTY: stay EMPTY; `ptr` unchanged.
- `req_ready` never depends on `req_a`/`req_b`. It depends on `req_valid`, `ptr`, state and `rsp_ready` only.
- Requesters must hold `req_valid` and their operands stable until granted. The block does not check this.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0.
  - `ptr`=0, state EMPTY.
  - `req_ready` evaluates to the grant for `ptr`=0, i.e. the lowest-index valid requester.
- Latency: request granted in cycle t -> `rsp_valid`/`rsp_sum` visible after the edge ending cycle t, i.e. 1 cycle.
- Backpressure: while FULL and `rsp_ready`=0, `rsp_sum`/`rsp_id` are stable and no requester is granted.
- Fairness: a continuously asserting requester waits at most N_REQ-1 grants to other requesters.
- Reset asserted mid-operation: immediately clears `rsp_valid` and `ptr`. The held result is dropped, not delivered.
- Combinational paths: `rsp_ready` -> `req_ready` and `req_valid` -> `req_ready`. There is no combinational path from inputs to `rsp_*`.

## Configuration
- `SHARED_ADDER_CARRY_EN`:
  - Defined: adds output port `rsp_carry` (out, 1). It is bit WIDTH of a+b, registered alongside `rsp_sum`, resets to 0, and holds under backpressure.
  - Undefined: the port is absent and the carry is discarded.
  - `rsp_sum` behaviour is identical in both builds.

## Test plan
- Single request: requester 0, a=4'b0010, b=4'b1100 -> `req_ready`=4'b0001 that cycle; next cycle `rsp_valid`=1, `rsp_sum`=14, `rsp_id`=0.
- Wrap-around: requester 2, a=12, b=5 -> `rsp_sum`=1, `rsp_id`=2; with `SHARED_ADDER_CARRY_EN`, `rsp_carry`=1. Also 0+15 -> 15, carry 0.
- Round-robin: all four `req_valid` held high, `rsp_ready`=1 -> grants 0,1,2,3,0 on consecutive cycles; `rsp_valid` stays high and `rsp_id` follows 0,1,2,3,0 one cycle later.
- Backpressure: result pending, `rsp_ready`=0 for 3 cycles with requesters 1 and 3 valid -> `req_ready`=0, `rsp_sum`/`rsp_id` stable. On the cycle `rsp_ready` rises, the next requester from `ptr` is granted in the same cycle.
- Drain: FULL, `rsp_ready`=1, no `req_valid` -> next cycle `rsp_valid`=0 and `rsp_sum` retains its last value.
- Reset mid-operation: FULL with `rsp_sum`=9, `rsp_id`=3; pulse `rst_n` low between edges -> `rsp_valid`, `rsp_sum`, `rsp_id` are 0 immediately. After release, with all requesters valid, requester 0 is granted first.
